// File: rtl/fb_pkg.sv
// Frame-buffer geometry shared by the write-back path and the write arbiter.
package fb_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 24;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] rgb;
        logic                 last;
    } fb_pixel_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Pixel-core input handshake plus frame-buffer port-A write side of the arbiter.
interface fb_write_arbiter_if #(
    parameter int NUM_CORES = 2,
    parameter int COORD_W   = 11,
    parameter int DATA_W    = 24,
    parameter int ADDR_W    = 19
);
    logic [NUM_CORES-1:0]         in_valid;
    logic [NUM_CORES-1:0]         in_ready;
    logic [NUM_CORES*COORD_W-1:0] in_x;
    logic [NUM_CORES*COORD_W-1:0] in_y;
    logic [NUM_CORES*DATA_W-1:0]  in_rgb;
    logic                         wea;
    logic [ADDR_W-1:0]            addra;
    logic [DATA_W-1:0]            dina;
    logic                         frame_done;
    logic [ADDR_W:0]              pixel_count;
    logic                         dropped;

    modport master (
        output in_valid, in_x, in_y, in_rgb,
        input  in_ready, wea, addra, dina, frame_done, pixel_count, dropped
    );

    modport slave (
        input  in_valid, in_x, in_y, in_rgb,
        output in_ready, wea, addra, dina, frame_done, pixel_count, dropped
    );
endinterface

// File: rtl/fb_write_arbiter_rr.sv
// Combinational round-robin picker: first valid at or above ptr_i (with wrap) wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    always_comb begin
        dbl   = {valid_i, valid_i};
        rot   = N'(dbl >> ptr_i);
        sum   = '0;
        any_o = 1'b0;
        idx_o = '0;
        // rot[k] is core (ptr+k) mod N, so the lowest set bit is the winner
        for (int k = 0; k < N; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                sum   = (IW+1)'(ptr_i) + (IW+1)'(k);
            end
        end
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx_o   = IW'(sum);
        grant_o = any_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// Merges NUM_CORES pixel streams into one frame-buffer write port: round-robin
// grant, linear address, off-screen drop, output pipeline and frame counting.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int COORD_W    = 11,
    parameter int DATA_W     = FB_DATA_W,
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int WIDTH      = FB_WIDTH,
    parameter int HEIGHT     = FB_HEIGHT,
    parameter int OUT_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_clear,
    fb_write_arbiter_if.slave   bus
);
    localparam int IW     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PIXELS = WIDTH * HEIGHT;
    localparam logic [ADDR_W:0] PIX_L = (ADDR_W+1)'(PIXELS);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rgb;
        logic              last;
    } stage_t;

    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0] grant;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic                 xfer;
    logic [COORD_W-1:0]   sel_x, sel_y;
    logic [DATA_W-1:0]    sel_rgb;
    logic                 in_range;
    logic [ADDR_W-1:0]    lin_addr;
    logic [ADDR_W:0]      cnt_q, cnt_d, cnt_inc;
    logic                 dropped_q, dropped_d;
    logic                 last_d;
    logic                 s0_vld_d;

    logic [OUT_STAGES:0]  vld_q;
    stage_t               pix_q [0:OUT_STAGES];

    rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_rr (
        .valid_i (bus.in_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign bus.in_ready = rst_n ? grant : '0;
    assign xfer         = gnt_any & rst_n;

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_rgb = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (grant[c]) begin
                sel_x   = bus.in_x[c*COORD_W +: COORD_W];
                sel_y   = bus.in_y[c*COORD_W +: COORD_W];
                sel_rgb = bus.in_rgb[c*DATA_W +: DATA_W];
            end
        end
        in_range = (int'(sel_x) < WIDTH) && (int'(sel_y) < HEIGHT);
        // 640 = 512 + 128, so the common case needs no multiplier
        if (WIDTH == 640) begin
            lin_addr = (ADDR_W'(sel_y) << 9) + (ADDR_W'(sel_y) << 7) + ADDR_W'(sel_x);
        end else begin
            lin_addr = ADDR_W'(sel_y) * ADDR_W'(WIDTH) + ADDR_W'(sel_x);
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        cnt_inc   = (frame_clear ? '0 : cnt_q) + (ADDR_W+1)'(1);
        cnt_d     = frame_clear ? '0 : cnt_q;
        dropped_d = frame_clear ? 1'b0 : dropped_q;
        last_d    = 1'b0;
        s0_vld_d  = xfer & in_range;
        if (xfer) begin
            rr_ptr_d = (gnt_idx == IW'(NUM_CORES-1)) ? '0 : gnt_idx + IW'(1);
            if (in_range) begin
                if (cnt_inc == PIX_L) begin
                    cnt_d  = '0;
                    last_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else begin
                dropped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
            vld_q     <= '0;
            for (int s = 0; s <= OUT_STAGES; s++) begin
                pix_q[s] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
            vld_q[0]  <= s0_vld_d;
            if (s0_vld_d) begin
                pix_q[0] <= '{addr: lin_addr, rgb: sel_rgb, last: last_d};
            end
            // payload only moves with a valid pixel so idle cycles keep the bus quiet
            for (int s = 1; s <= OUT_STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    pix_q[s] <= pix_q[s-1];
                end
            end
        end
    end

    assign bus.wea         = vld_q[OUT_STAGES];
    assign bus.addra       = pix_q[OUT_STAGES].addr;
    assign bus.dina        = pix_q[OUT_STAGES].rgb;
    assign bus.frame_done  = vld_q[OUT_STAGES] & pix_q[OUT_STAGES].last;
    assign bus.pixel_count = cnt_q;
    assign bus.dropped     = dropped_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench: dut_a is the default 640x480 / 2 cores / 2 out stages build,
// dut_b a 16x8 / 4 cores / 0 out stages build used for the full-frame run.
module tb_fb_write_arbiter;
    logic clk;
    logic rst_a_n, rst_b_n;
    logic fc_a, fc_b;
    int   vectors;
    int   miscompares;

    fb_write_arbiter_if #(.NUM_CORES(2), .COORD_W(11), .DATA_W(24), .ADDR_W(19)) if_a ();
    fb_write_arbiter_if #(.NUM_CORES(4), .COORD_W(11), .DATA_W(24), .ADDR_W(7))  if_b ();

    fb_write_arbiter #(.NUM_CORES(2), .COORD_W(11), .DATA_W(24), .ADDR_W(19),
                       .WIDTH(640), .HEIGHT(480), .OUT_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .frame_clear(fc_a), .bus(if_a));

    fb_write_arbiter #(.NUM_CORES(4), .COORD_W(11), .DATA_W(24), .ADDR_W(7),
                       .WIDTH(16), .HEIGHT(8), .OUT_STAGES(0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .frame_clear(fc_b), .bus(if_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic a_set(input int c, input int x, input int y, input logic [23:0] rgb);
        if_a.in_x[c*11 +: 11]   = 11'(x);
        if_a.in_y[c*11 +: 11]   = 11'(y);
        if_a.in_rgb[c*24 +: 24] = rgb;
    endtask

    task automatic b_set(input int c, input int x, input int y, input logic [23:0] rgb);
        if_b.in_x[c*11 +: 11]   = 11'(x);
        if_b.in_y[c*11 +: 11]   = 11'(y);
        if_b.in_rgb[c*24 +: 24] = rgb;
    endtask

    task automatic reset_a();
        if_a.in_valid = '0;
        fc_a = 1'b0;
        rst_a_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic reset_b();
        if_b.in_valid = '0;
        fc_b = 1'b0;
        rst_b_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_b_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        fc_a = 1'b0;
        fc_b = 1'b0;
        a_set(0, 1, 1, 24'h111111);
        a_set(1, 2, 2, 24'h222222);
        for (int c = 0; c < 4; c++) b_set(c, c, 0, 24'h0);
        if_a.in_valid = 2'b11;
        if_b.in_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        vectors += 8;
        if (if_a.wea !== 1'b0) begin miscompares++; $display("FAIL rst_wea_a: got %b want 0", if_a.wea); end
        if (if_a.addra !== 19'd0) begin miscompares++; $display("FAIL rst_addra_a: got %0d want 0", if_a.addra); end
        if (if_a.dina !== 24'd0) begin miscompares++; $display("FAIL rst_dina_a: got %h want 0", if_a.dina); end
        if (if_a.frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_fdone_a: got %b want 0", if_a.frame_done); end
        if (if_a.pixel_count !== 20'd0) begin miscompares++; $display("FAIL rst_count_a: got %0d want 0", if_a.pixel_count); end
        if (if_a.dropped !== 1'b0) begin miscompares++; $display("FAIL rst_dropped_a: got %b want 0", if_a.dropped); end
        if (if_a.in_ready !== 2'b00) begin miscompares++; $display("FAIL rst_ready_a: got %b want 00", if_a.in_ready); end
        if (if_b.in_ready !== 4'b0000 || if_b.wea !== 1'b0) begin
            miscompares++; $display("FAIL rst_b: ready %b wea %b want 0000/0", if_b.in_ready, if_b.wea);
        end
        if_a.in_valid = '0;
        if_b.in_valid = '0;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        reset_a();
        a_set(0, 5, 2, 24'hABCDEF);
        if_a.in_valid = 2'b01;
        #1;
        vectors++;
        if (if_a.in_ready !== 2'b01) begin miscompares++; $display("FAIL single_ready: got %b want 01", if_a.in_ready); end
        @(negedge clk);
        if_a.in_valid = '0;
        vectors += 2;
        if (if_a.wea !== 1'b0) begin miscompares++; $display("FAIL single_early1: wea %b want 0", if_a.wea); end
        if (if_a.pixel_count !== 20'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", if_a.pixel_count); end
        @(negedge clk);
        vectors++;
        if (if_a.wea !== 1'b0) begin miscompares++; $display("FAIL single_early2: wea %b want 0", if_a.wea); end
        @(negedge clk);
        vectors += 3;
        if (if_a.wea !== 1'b1) begin miscompares++; $display("FAIL single_wea: got %b want 1", if_a.wea); end
        if (if_a.addra !== 19'd1285) begin miscompares++; $display("FAIL single_addra: got %0d want 1285", if_a.addra); end
        if (if_a.dina !== 24'hABCDEF) begin miscompares++; $display("FAIL single_dina: got %h want abcdef", if_a.dina); end
        @(negedge clk);
        vectors++;
        if (if_a.wea !== 1'b0) begin miscompares++; $display("FAIL single_after: wea %b want 0", if_a.wea); end
    endtask

    task automatic test_round_robin();
        int k0, k1, j, core, kc;
        logic [18:0] ea;
        logic [23:0] ed;
        logic [1:0]  er;
        reset_a();
        k0 = 0;
        k1 = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            vectors++;
            if (i >= 3) begin
                j    = i - 3;
                core = j % 2;
                kc   = j / 2;
                ea   = 19'((kc + 1) * 640 + core * 100 + kc);
                ed   = 24'(32'hC0005A + (core << 16) + (kc << 8));
                if (if_a.wea !== 1'b1 || if_a.addra !== ea || if_a.dina !== ed || if_a.frame_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rr_write%0d: wea %b addr %0d data %h fd %b want 1 %0d %h 0",
                             j, if_a.wea, if_a.addra, if_a.dina, if_a.frame_done, ea, ed);
                end
            end else if (if_a.wea !== 1'b0) begin
                miscompares++; $display("FAIL rr_idle%0d: wea %b want 0", i, if_a.wea);
            end
            if (i < 8) begin
                a_set(0, k0, k0 + 1, 24'(32'hC0005A + (k0 << 8)));
                a_set(1, 100 + k1, k1 + 1, 24'(32'hC1005A + (k1 << 8)));
                if_a.in_valid = 2'b11;
                #1;
                er = (i % 2 == 0) ? 2'b01 : 2'b10;
                vectors++;
                if (if_a.in_ready !== er) begin
                    miscompares++; $display("FAIL rr_grant%0d: got %b want %b", i, if_a.in_ready, er);
                end
                if (if_a.in_ready[0]) k0++;
                else if (if_a.in_ready[1]) k1++;
            end else begin
                if_a.in_valid = '0;
            end
        end
        @(negedge clk);
        vectors += 2;
        if (if_a.wea !== 1'b0) begin miscompares++; $display("FAIL rr_tail: wea %b want 0", if_a.wea); end
        if (if_a.pixel_count !== 20'd8) begin miscompares++; $display("FAIL rr_count: got %0d want 8", if_a.pixel_count); end
    endtask

    task automatic test_offscreen();
        @(negedge clk);
        a_set(1, 640, 0, 24'h123456);
        if_a.in_valid = 2'b10;
        #1;
        vectors++;
        if (if_a.in_ready !== 2'b10) begin miscompares++; $display("FAIL off_ready_x: got %b want 10", if_a.in_ready); end
        @(negedge clk);
        a_set(1, 0, 480, 24'h654321);
        #1;
        vectors++;
        if (if_a.in_ready !== 2'b10) begin miscompares++; $display("FAIL off_ready_y: got %b want 10", if_a.in_ready); end
        @(negedge clk);
        if_a.in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (if_a.wea !== 1'b0) begin miscompares++; $display("FAIL off_nowrite%0d: wea %b want 0", i, if_a.wea); end
            @(negedge clk);
        end
        vectors += 2;
        if (if_a.pixel_count !== 20'd8) begin miscompares++; $display("FAIL off_count: got %0d want 8", if_a.pixel_count); end
        if (if_a.dropped !== 1'b1) begin miscompares++; $display("FAIL off_dropped: got %b want 1", if_a.dropped); end
        fc_a = 1'b1;
        @(negedge clk);
        fc_a = 1'b0;
        vectors += 2;
        if (if_a.dropped !== 1'b0) begin miscompares++; $display("FAIL off_clr_dropped: got %b want 0", if_a.dropped); end
        if (if_a.pixel_count !== 20'd0) begin miscompares++; $display("FAIL off_clr_count: got %0d want 0", if_a.pixel_count); end
    endtask

    task automatic test_clear_coincide();
        a_set(0, 1, 0, 24'h000001);
        if_a.in_valid = 2'b01;
        @(negedge clk);
        a_set(0, 2, 0, 24'h000002);
        @(negedge clk);
        a_set(0, 7, 3, 24'h0000C7);
        fc_a = 1'b1;
        #1;
        vectors++;
        if (if_a.in_ready !== 2'b01) begin miscompares++; $display("FAIL clr_ready: got %b want 01", if_a.in_ready); end
        @(negedge clk);
        fc_a = 1'b0;
        if_a.in_valid = '0;
        vectors += 3;
        if (if_a.pixel_count !== 20'd1) begin miscompares++; $display("FAIL clr_count: got %0d want 1", if_a.pixel_count); end
        if (if_a.wea !== 1'b1 || if_a.addra !== 19'd1) begin
            miscompares++; $display("FAIL clr_pre1: wea %b addr %0d want 1 1", if_a.wea, if_a.addra);
        end
        if (if_a.dropped !== 1'b0) begin miscompares++; $display("FAIL clr_dropped0: got %b want 0", if_a.dropped); end
        @(negedge clk);
        vectors++;
        if (if_a.wea !== 1'b1 || if_a.addra !== 19'd2) begin
            miscompares++; $display("FAIL clr_pre2: wea %b addr %0d want 1 2", if_a.wea, if_a.addra);
        end
        @(negedge clk);
        vectors++;
        if (if_a.wea !== 1'b1 || if_a.addra !== 19'd1927 || if_a.dina !== 24'h0000C7) begin
            miscompares++; $display("FAIL clr_pixel: wea %b addr %0d data %h want 1 1927 0000c7", if_a.wea, if_a.addra, if_a.dina);
        end
        @(negedge clk);
        vectors++;
        if (if_a.wea !== 1'b0) begin miscompares++; $display("FAIL clr_tail: wea %b want 0", if_a.wea); end
        a_set(0, 700, 1, 24'h0);
        if_a.in_valid = 2'b01;
        fc_a = 1'b1;
        @(negedge clk);
        fc_a = 1'b0;
        if_a.in_valid = '0;
        vectors += 2;
        if (if_a.dropped !== 1'b1) begin miscompares++; $display("FAIL clr_drop_wins: got %b want 1", if_a.dropped); end
        if (if_a.pixel_count !== 20'd0) begin miscompares++; $display("FAIL clr_drop_count: got %0d want 0", if_a.pixel_count); end
    endtask

    task automatic test_reset_inflight_a();
        reset_a();
        for (int i = 0; i < 3; i++) begin
            a_set(0, 10 + i, 4, 24'(i));
            if_a.in_valid = 2'b01;
            @(negedge clk);
        end
        if_a.in_valid = '0;
        vectors++;
        if (if_a.wea !== 1'b1 || if_a.addra !== 19'd2570) begin
            miscompares++; $display("FAIL rsta_first: wea %b addr %0d want 1 2570", if_a.wea, if_a.addra);
        end
        #1 rst_a_n = 1'b0;
        #1;
        vectors++;
        if (if_a.wea !== 1'b0 || if_a.addra !== 19'd0) begin
            miscompares++; $display("FAIL rsta_immediate: wea %b addr %0d want 0 0", if_a.wea, if_a.addra);
        end
        repeat (2) @(negedge clk);
        rst_a_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (if_a.wea !== 1'b0) begin miscompares++; $display("FAIL rsta_quiet%0d: wea %b want 0", i, if_a.wea); end
        end
        vectors++;
        if (if_a.pixel_count !== 20'd0) begin miscompares++; $display("FAIL rsta_count: got %0d want 0", if_a.pixel_count); end
        a_set(0, 3, 1, 24'h00BEEF);
        if_a.in_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if_a.in_valid = '0;
            vectors++;
            if (i < 2 && if_a.wea !== 1'b0) begin
                miscompares++; $display("FAIL rsta_lat%0d: wea %b want 0", i, if_a.wea);
            end else if (i == 2 && (if_a.wea !== 1'b1 || if_a.addra !== 19'd643 || if_a.dina !== 24'h00BEEF)) begin
                miscompares++; $display("FAIL rsta_new: wea %b addr %0d data %h want 1 643 00beef", if_a.wea, if_a.addra, if_a.dina);
            end
        end
    endtask

    task automatic test_reset_inflight_b();
        reset_b();
        for (int i = 0; i < 3; i++) begin
            b_set(2, i, 5, 24'(i));
            if_b.in_valid = 4'b0100;
            @(negedge clk);
            vectors++;
            if (if_b.wea !== 1'b1 || if_b.addra !== 7'(80 + i)) begin
                miscompares++; $display("FAIL rstb_pre%0d: wea %b addr %0d want 1 %0d", i, if_b.wea, if_b.addra, 80 + i);
            end
        end
        if_b.in_valid = '0;
        #1 rst_b_n = 1'b0;
        #1;
        vectors++;
        if (if_b.wea !== 1'b0) begin miscompares++; $display("FAIL rstb_immediate: wea %b want 0", if_b.wea); end
        repeat (2) @(negedge clk);
        rst_b_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (if_b.wea !== 1'b0) begin miscompares++; $display("FAIL rstb_quiet: wea %b want 0", if_b.wea); end
        b_set(3, 15, 7, 24'h00F00D);
        if_b.in_valid = 4'b1000;
        #1;
        vectors++;
        if (if_b.in_ready !== 4'b1000) begin miscompares++; $display("FAIL rstb_ready: got %b want 1000", if_b.in_ready); end
        @(negedge clk);
        if_b.in_valid = '0;
        vectors++;
        if (if_b.wea !== 1'b1 || if_b.addra !== 7'd127 || if_b.dina !== 24'h00F00D) begin
            miscompares++; $display("FAIL rstb_new: wea %b addr %0d data %h want 1 127 00f00d", if_b.wea, if_b.addra, if_b.dina);
        end
    endtask

    task automatic test_full_frame();
        bit        seen [128];
        int        next_k [4];
        bit  [3:0] pend;
        bit  [3:0] er;
        int        ptr, g, p, writes, fdones;
        reset_b();
        for (int i = 0; i < 128; i++) seen[i] = 1'b0;
        for (int c = 0; c < 4; c++) next_k[c] = 0;
        pend = '0;
        ptr = 0;
        writes = 0;
        fdones = 0;
        for (int cyc = 0; cyc < 3000 && writes < 128; cyc++) begin
            @(negedge clk);
            if (if_b.wea === 1'b1) begin
                p = int'(if_b.addra);
                vectors++;
                if (seen[p] || if_b.dina !== 24'(p * 3)) begin
                    miscompares++; $display("FAIL frame_pixel: addr %0d data %h dup %b want data %h", p, if_b.dina, seen[p], 24'(p * 3));
                end
                seen[p] = 1'b1;
                writes++;
            end
            if (if_b.frame_done === 1'b1) begin
                fdones++;
                vectors++;
                if (if_b.wea !== 1'b1 || writes != 128) begin
                    miscompares++; $display("FAIL frame_done_pos: wea %b writes %0d want 1 128", if_b.wea, writes);
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (!pend[c] && next_k[c] < 32 && $urandom_range(0, 3) != 0) begin
                    pend[c] = 1'b1;
                    p = c + 4 * next_k[c];
                    b_set(c, p % 16, p / 16, 24'(p * 3));
                end
            end
            if_b.in_valid = pend;
            #1;
            er = '0;
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && pend[(ptr + k) % 4]) g = (ptr + k) % 4;
            end
            if (g >= 0) er[g] = 1'b1;
            vectors++;
            if (if_b.in_ready !== er) begin
                miscompares++; $display("FAIL frame_grant: got %b want %b (valid %b)", if_b.in_ready, er, pend);
            end
            if (g >= 0) begin
                pend[g] = 1'b0;
                next_k[g]++;
                ptr = (g + 1) % 4;
            end
        end
        if_b.in_valid = '0;
        @(negedge clk);
        vectors += 4;
        if (writes != 128) begin miscompares++; $display("FAIL frame_writes: got %0d want 128", writes); end
        if (fdones != 1) begin miscompares++; $display("FAIL frame_done_count: got %0d want 1", fdones); end
        if (if_b.pixel_count !== 8'd0) begin miscompares++; $display("FAIL frame_count: got %0d want 0", if_b.pixel_count); end
        if (if_b.wea !== 1'b0 || if_b.frame_done !== 1'b0) begin
            miscompares++; $display("FAIL frame_tail: wea %b fd %b want 0 0", if_b.wea, if_b.frame_done);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        if_a.in_valid = '0;
        if_a.in_x = '0;
        if_a.in_y = '0;
        if_a.in_rgb = '0;
        if_b.in_valid = '0;
        if_b.in_x = '0;
        if_b.in_y = '0;
        if_b.in_rgb = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_offscreen();
        test_clear_coincide();
        test_reset_inflight_a();
        test_reset_inflight_b();
        test_full_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
